// File: rtl/ram_burst_writer.sv
// ram_burst_writer: streams burst data into a RAM with two write ports, pairing words into one write per cycle.
// Optional READBACK_CHECK_EN reads the burst back and compares XOR signatures (chk_err).
module ram_burst_writer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  we_a,
    output logic                  we_b,
    output logic [ADDR_WIDTH-1:0] addr_c,
    output logic [ADDR_WIDTH-1:0] addr_d,
    input  logic [DATA_WIDTH-1:0] q_c,
    input  logic [DATA_WIDTH-1:0] q_d,
    output logic                  busy,
    output logic                  done,
    output logic                  chk_err
);
    typedef enum logic [2:0] {IDLE, FILL, TAIL, CHECK, FINISH} state_t;
`ifdef READBACK_CHECK_EN
    localparam state_t AFTER = CHECK;
`else
    localparam state_t AFTER = FINISH;
`endif
    state_t state, next;
    logic [ADDR_WIDTH-1:0] base, wr_addr;
    logic [LEN_WIDTH-1:0] len, cnt;
    logic [DATA_WIDTH-1:0] pair;
    logic cmd_fire, wr_fire, all_in, last_word, check_done;

    assign cmd_ready = state == IDLE;
    assign wr_ready  = state == FILL && !all_in;
    assign busy      = state != IDLE;
    assign done      = state == FINISH;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign all_in    = cnt == len;
    assign last_word = cnt + LEN_WIDTH'(1) == len;
    assign wr_addr   = base + ADDR_WIDTH'(cnt);

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : next;
    end

    // An even-length burst lingers one FILL cycle after its last word so done follows the final write.
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = cmd_fire ? (cmd_len == '0 ? FINISH : FILL) : IDLE;
            FILL:    next = all_in ? AFTER : (wr_fire && last_word && !cnt[0]) ? TAIL : FILL;
            TAIL:    next = AFTER;
            CHECK:   next = check_done ? FINISH : CHECK;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base   <= '0;
            len    <= '0;
            cnt    <= '0;
            pair   <= '0;
            addr_a <= '0;
            addr_b <= '0;
            data_a <= '0;
            data_b <= '0;
            we_a   <= 1'b0;
            we_b   <= 1'b0;
        end else begin
            we_a <= 1'b0;
            we_b <= 1'b0;
            if (cmd_fire) begin
                base <= cmd_addr;
                len  <= cmd_len;
                cnt  <= '0;
            end
            if (wr_fire) begin
                cnt <= cnt + LEN_WIDTH'(1);
                if (cnt[0]) begin
                    addr_a <= wr_addr - ADDR_WIDTH'(1);
                    addr_b <= wr_addr;
                    data_a <= pair;
                    data_b <= wr_data;
                    we_a   <= 1'b1;
                    we_b   <= 1'b1;
                end else begin
                    pair <= wr_data;
                    if (last_word) begin
                        addr_a <= wr_addr;
                        data_a <= wr_data;
                        we_a   <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef READBACK_CHECK_EN
    logic [LEN_WIDTH:0] rcnt, rlen;
    logic [DATA_WIDTH-1:0] wsig, rsig;
    logic issue, v1, v2, odd1, odd2;

    assign rlen       = {1'b0, len};
    assign issue      = state == CHECK && rcnt < rlen;
    assign check_done = rcnt >= rlen && !v1 && !v2;

    // v1 marks a read address on the port, v2 the cycle its data is returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt    <= '0;
            wsig    <= '0;
            rsig    <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            odd1    <= 1'b0;
            odd2    <= 1'b0;
            addr_c  <= '0;
            addr_d  <= '0;
            chk_err <= 1'b0;
        end else begin
            v1   <= issue;
            odd1 <= issue && rcnt + (LEN_WIDTH+1)'(1) == rlen;
            v2   <= v1;
            odd2 <= odd1;
            if (issue) begin
                addr_c <= base + ADDR_WIDTH'(rcnt);
                addr_d <= base + ADDR_WIDTH'(rcnt) + ADDR_WIDTH'(1);
                rcnt   <= rcnt + (LEN_WIDTH+1)'(2);
            end
            if (v2)
                rsig <= rsig ^ q_c ^ (odd2 ? '0 : q_d);
            if (wr_fire)
                wsig <= wsig ^ wr_data;
            if (state == CHECK && check_done)
                chk_err <= rsig != wsig;
            if (cmd_fire) begin
                rcnt    <= '0;
                wsig    <= '0;
                rsig    <= '0;
                chk_err <= 1'b0;
            end
        end
    end
`else
    logic unused_q;
    assign unused_q   = ^{q_c, q_d};
    assign addr_c     = '0;
    assign addr_d     = '0;
    assign chk_err    = 1'b0;
    assign check_done = 1'b1;
`endif
endmodule

// File: tb/tb_ram_burst_writer.sv
// tb_ram_burst_writer: directed vector table plus hand sequences for abort and readback.
module tb_ram_burst_writer;
    logic clk, reset, cmd_valid, cmd_ready, wr_valid, wr_ready;
    logic [11:0] cmd_addr, addr_a, addr_b, addr_c, addr_d;
    logic [7:0] cmd_len;
    logic [31:0] wr_data, data_a, data_b, q_c, q_d;
    logic we_a, we_b, busy, done, chk_err;
    logic corrupt_en = 1'b0;
    logic [31:0] mem [4096];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rst, cv;
        logic [11:0] ca;
        logic [7:0] cl;
        logic wv;
        logic [31:0] wd;
        logic ea, eb;
        logic [11:0] aa, ab;
        logic [31:0] da, db;
        logic dn, bz, cr, wr;
    } vec_t;
    vec_t vq[$];

    ram_burst_writer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
        .we_a(we_a), .we_b(we_b),
        .addr_c(addr_c), .addr_d(addr_d), .q_c(q_c), .q_d(q_d),
        .busy(busy), .done(done), .chk_err(chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-write, two-read RAM with registered reads; q_c can be corrupted at address 102.
    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
        q_c <= mem[addr_c] ^ ((corrupt_en && addr_c == 12'd102) ? 32'h10 : 32'h0);
        q_d <= mem[addr_d];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, cv, input logic [11:0] ca, input logic [7:0] cl,
                       input logic wv, input logic [31:0] wd, input logic ea, eb,
                       input logic [11:0] aa, ab, input logic [31:0] da, db,
                       input logic dn, bz, cr, wr);
        vq.push_back('{r, cv, ca, cl, wv, wd, ea, eb, aa, ab, da, db, dn, bz, cr, wr});
    endtask

`ifdef READBACK_CHECK_EN
    task automatic burst(input logic [11:0] b, input logic [7:0] l, input logic [31:0] s,
                         input logic exp_err, input string nm);
        cmd_valid = 1'b1;
        cmd_addr  = b;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
        chk({nm, " chk_err cleared"}, chk_err, 0);
        wr_valid = 1'b1;
        for (int i = 0; i < int'(l); i++) begin
            wr_data = s + i;
            tick();
        end
        wr_valid = 1'b0;
        for (int n = 0; n < 60 && !done; n++) tick();
        chk({nm, " done"}, done, 1);
        chk({nm, " chk_err"}, chk_err, exp_err);
        tick();
        chk({nm, " chk_err hold"}, chk_err, exp_err);
    endtask
`endif

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; wr_valid = 1'b0; wr_data = '0;
        tick();
        tick();
        chk("rst we", {we_a, we_b}, 0);
        chk("rst busy/done", {busy, done}, 0);
        chk("rst ready", {cmd_ready, wr_ready}, 2'b10);
        chk("rst addr", {addr_a, addr_b, addr_c, addr_d}, 0);
        chk("rst data", data_a | data_b, 0);
        chk("rst chk_err", chk_err, 0);
        reset = 1'b0;
        tick();

`ifndef READBACK_CHECK_EN
        //  rst cv  ca    cl  wv wd   ea eb aa    ab  da  db  dn bz cr wr
        add(1, 1,  5,    3,  0, 0,   0, 0, 0,    0,  0,  0,  0, 0, 1, 0);
        add(0, 1,  10,   4,  0, 0,   0, 0, 0,    0,  0,  0,  0, 1, 0, 1);
        add(0, 0,  0,    0,  1, 11,  0, 0, 0,    0,  0,  0,  0, 1, 0, 1);
        add(0, 0,  0,    0,  1, 22,  1, 1, 10,   11, 11, 22, 0, 1, 0, 1);
        add(0, 0,  0,    0,  1, 33,  0, 0, 0,    0,  0,  0,  0, 1, 0, 1);
        add(0, 0,  0,    0,  1, 44,  1, 1, 12,   13, 33, 44, 0, 1, 0, 0);
        add(0, 0,  0,    0,  0, 0,   0, 0, 0,    0,  0,  0,  1, 1, 0, 0);
        add(0, 0,  0,    0,  0, 0,   0, 0, 0,    0,  0,  0,  0, 0, 1, 0);
        add(0, 1,  20,   3,  0, 0,   0, 0, 0,    0,  0,  0,  0, 1, 0, 1);
        add(0, 0,  0,    0,  1, 5,   0, 0, 0,    0,  0,  0,  0, 1, 0, 1);
        add(0, 0,  0,    0,  0, 99,  0, 0, 0,    0,  0,  0,  0, 1, 0, 1);
        add(0, 0,  0,    0,  1, 6,   1, 1, 20,   21, 5,  6,  0, 1, 0, 1);
        add(0, 0,  0,    0,  1, 7,   1, 0, 22,   0,  7,  0,  0, 1, 0, 0);
        add(0, 0,  0,    0,  0, 0,   0, 0, 0,    0,  0,  0,  1, 1, 0, 0);
        add(0, 0,  0,    0,  0, 0,   0, 0, 0,    0,  0,  0,  0, 0, 1, 0);
        add(0, 1,  4095, 2,  0, 0,   0, 0, 0,    0,  0,  0,  0, 1, 0, 1);
        add(0, 1,  100,  5,  1, 1,   0, 0, 0,    0,  0,  0,  0, 1, 0, 1);
        add(0, 1,  100,  5,  1, 2,   1, 1, 4095, 0,  1,  2,  0, 1, 0, 0);
        add(0, 1,  100,  5,  0, 0,   0, 0, 0,    0,  0,  0,  1, 1, 0, 0);
        add(0, 0,  0,    0,  0, 0,   0, 0, 0,    0,  0,  0,  0, 0, 1, 0);
        add(0, 1,  7,    0,  1, 55,  0, 0, 0,    0,  0,  0,  1, 1, 0, 0);
        add(0, 0,  0,    0,  1, 55,  0, 0, 0,    0,  0,  0,  0, 0, 1, 0);
        add(0, 0,  0,    0,  1, 56,  0, 0, 0,    0,  0,  0,  0, 0, 1, 0);
        foreach (vq[i]) begin
            reset = vq[i].rst; cmd_valid = vq[i].cv; cmd_addr = vq[i].ca; cmd_len = vq[i].cl;
            wr_valid = vq[i].wv; wr_data = vq[i].wd;
            tick();
            chk($sformatf("r%0d we_a", i), we_a, vq[i].ea);
            chk($sformatf("r%0d we_b", i), we_b, vq[i].eb);
            chk($sformatf("r%0d done", i), done, vq[i].dn);
            chk($sformatf("r%0d busy", i), busy, vq[i].bz);
            chk($sformatf("r%0d cmd_ready", i), cmd_ready, vq[i].cr);
            chk($sformatf("r%0d wr_ready", i), wr_ready, vq[i].wr);
            chk($sformatf("r%0d read side idle", i), {addr_c, addr_d, chk_err}, 0);
            if (vq[i].ea) chk($sformatf("r%0d port a", i), {addr_a, data_a[19:0]}, {vq[i].aa, vq[i].da[19:0]});
            if (vq[i].eb) chk($sformatf("r%0d port b", i), {addr_b, data_b[19:0]}, {vq[i].ab, vq[i].db[19:0]});
        end
        reset = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0;
`endif

        cmd_valid = 1'b1; cmd_addr = 12'd50; cmd_len = 8'd6;
        tick();
        cmd_valid = 1'b0;
        wr_valid = 1'b1; wr_data = 32'hA0;
        tick();
        wr_data = 32'hA1;
        tick();
        chk("abort pair we", {we_a, we_b}, 2'b11);
        chk("abort pair addr", {addr_a, addr_b}, {12'd50, 12'd51});
        wr_data = 32'hA2; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort rst we", {we_a, we_b}, 0);
        chk("abort rst status", {busy, done, cmd_ready, wr_ready}, 4'b0010);
        chk("abort rst outputs", {addr_a, data_b}, 0);
        for (int n = 0; n < 6; n++) begin
            wr_data = 32'hB0 + n;
            tick();
            chk($sformatf("abort after %0d", n), {we_a, we_b, done, busy, cmd_ready}, 5'b00001);
        end
        wr_valid = 1'b0;

`ifdef READBACK_CHECK_EN
        burst(12'd202, 8'd2, 32'hDEAD, 1'b0, "pre");
        burst(12'd100, 8'd4, 32'h1000, 1'b0, "clean");
        corrupt_en = 1'b1;
        burst(12'd100, 8'd4, 32'h2000, 1'b1, "corrupt");
        corrupt_en = 1'b0;
        burst(12'd200, 8'd3, 32'h3000, 1'b0, "odd tail");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_burst_writer.md
RAM_BURST_WRITER -- requirements
Module: ram_burst_writer

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, shall set the RAM word address width.
REQ-002 Parameter DATA_WIDTH, default 32, shall set the RAM word width.
REQ-003 Parameter LEN_WIDTH, default 8, shall set the burst length field width.
REQ-004 Port clk, input, 1, shall be the only clock; all logic updates on its rising edge.
REQ-005 Port reset, input, 1, shall be the reset; it is synchronous and active-high.
REQ-006 Ports cmd_valid/cmd_ready (in/out, 1), cmd_addr (in, ADDR_WIDTH) and cmd_len (in, LEN_WIDTH, words) shall form the burst command channel.
REQ-007 Ports wr_valid/wr_ready (in/out, 1) and wr_data (in, DATA_WIDTH) shall form the write-data stream.
REQ-008 Ports addr_a, addr_b (out, ADDR_WIDTH), data_a, data_b (out, DATA_WIDTH) and we_a, we_b (out, 1) shall drive the RAM's two write ports.
REQ-009 Ports addr_c, addr_d (out, ADDR_WIDTH) and q_c, q_d (in, DATA_WIDTH) shall connect to two RAM read ports; read data is valid one clock after the address is presented.
REQ-010 Ports busy (out, 1), done (out, 1, one-cycle pulse) and chk_err (out, 1) shall report status.

Function
REQ-011 FSM states shall be IDLE, FILL, TAIL, CHECK and FINISH.
REQ-012 In IDLE, cmd_ready shall be 1; a command is accepted on a cycle with cmd_valid && cmd_ready; base and length are latched.
REQ-013 cmd_len = 0 shall go directly to FINISH, performing no writes and no reads.
REQ-014 In FILL, wr_ready shall be 1; accepted words shall be counted as offset i = 0..len-1.
REQ-015 An even-offset word shall be held in a one-word pair register; no write is issued for it.
REQ-016 When the following odd-offset word is accepted, the next cycle shall present addr_a = base+i-1, data_a = held word, addr_b = base+i, data_b = new word, with we_a = we_b = 1 for exactly that cycle.
REQ-017 Address arithmetic shall be modulo 2^ADDR_WIDTH; for example, base 4095 with offset 1 gives address 0.
REQ-018 When a FILL word completes an odd-length burst, the FSM shall enter TAIL; TAIL shall drive addr_a = base+len-1 and data_a = held word with we_a = 1 and we_b = 0 for one cycle.
REQ-019 we_a and we_b shall be 0 in every cycle not covered by REQ-016 and REQ-018; wr_ready shall be 0 outside FILL.
REQ-020 When all words are written, the FSM shall enter CHECK if READBACK_CHECK_EN is defined, otherwise FINISH.
REQ-021 FINISH shall last one cycle with done = 1, then return to IDLE.
REQ-022 busy shall be 1 in every state except IDLE.
REQ-023 wr_valid low in FILL shall stall without side effects; no gaps are required between words.
REQ-024 Outputs to the RAM shall be registered.

Reset
REQ-025 While reset = 1, the FSM shall enter IDLE, and we_a, we_b, done, busy and chk_err shall be 0.
REQ-026 While reset = 1, all address and data outputs shall be 0, and the counters and pair register shall be cleared.
REQ-027 Reset asserted mid-burst shall abort the burst; no further writes shall occur and done shall not pulse for that burst.
REQ-028 Reset shall take priority over all other inputs in the same cycle.

Configuration
REQ-029 Macro READBACK_CHECK_EN, when defined, shall compile in the CHECK state, addr_c/addr_d sequencing and chk_err.
REQ-030 With READBACK_CHECK_EN defined, every word written shall be XOR-folded into a write signature.
REQ-031 With READBACK_CHECK_EN defined, CHECK shall read two words per cycle: addr_c = base+2k and addr_d = base+2k+1.
REQ-032 With READBACK_CHECK_EN defined, q_c and q_d shall be XOR-folded one cycle later; q_d shall be ignored for an odd tail.
REQ-033 With READBACK_CHECK_EN defined, on the final compare chk_err shall be set to 1 if the signatures differ, else 0.
REQ-034 With READBACK_CHECK_EN defined, chk_err shall hold its value until the next accepted command.
REQ-035 Without READBACK_CHECK_EN, addr_c = addr_d = 0 constantly, chk_err = 0 constantly, and q_c/q_d shall be unused.

Verification
REQ-036 Reset, then cmd base=10, len=4, data 11,22,33,44 back-to-back -> two cycles with we_a=we_b=1 at (10,11)=(11,22) and (12,13)=(33,44); done one cycle later.
REQ-037 cmd base=20, len=3, data 5,6,7 -> one paired write (20,21)=(5,6), then TAIL we_a only at 22=7 with we_b=0; done pulses.
REQ-038 cmd base=4095, len=2, data 1,2 -> addr_a=4095 and addr_b=0 written in the same cycle.
REQ-039 cmd len=0 -> no we_a/we_b activity and done asserted within 2 cycles.
REQ-040 Reset asserted after the 2nd word of a len=6 burst -> no further we pulses, no done, busy=0, cmd_ready=1 on the following cycle.
REQ-041 With READBACK_CHECK_EN and a RAM model -> len=4 burst gives chk_err=0; forcing q_c to corrupt one word gives chk_err=1 after done.
